// File: rtl/pa_hash_sequencer_if.sv
// Handshake and core-side signal bundle for the privacy-amplification hash sequencer.
// The master modport is the sequencer; the slave modport is the stream/core environment.
interface pa_hash_sequencer_if #(
  parameter int PA_W = 64,
  parameter int PA_K = 1024
);
  logic            start;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [PA_W-1:0] rnd_word;
  logic            key_valid;
  logic            key_ready;
  logic [PA_W-1:0] key_word;
  logic            shift_en;
  logic [PA_W-1:0] random_bit;
  logic            key_en;
  logic [PA_W-1:0] key_bit;
  logic [PA_K-1:0] hash_product;
  logic [PA_K-1:0] hash_out;
  logic            hash_valid;
  logic            hash_ready;
  logic            busy;
  logic            done;

  modport master (
    input  start, rnd_valid, rnd_word, key_valid, key_word, hash_product, hash_ready,
    output rnd_ready, key_ready, shift_en, random_bit, key_en, key_bit,
           hash_out, hash_valid, busy, done
  );

  modport slave (
    output start, rnd_valid, rnd_word, key_valid, key_word, hash_product, hash_ready,
    input  rnd_ready, key_ready, shift_en, random_bit, key_en, key_bit,
           hash_out, hash_valid, busy, done
  );
endinterface

// File: rtl/pa_hash_sequencer.sv
// Initiator for the Toeplitz hashing core: preloads the shift chain, streams key beats
// with key_en held high for the whole accumulation, then captures and presents the hash.
module pa_hash_sequencer #(
  parameter int PA_W      = 64,
  parameter int PA_K      = 1024,
  parameter int PA_S      = 17,
  parameter int KEY_WORDS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  pa_hash_sequencer_if.master bus
);
  localparam int PRE_CW  = $clog2(PA_S + 1);
  localparam int BEAT_CW = $clog2(KEY_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_ACCUM,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PRE_CW-1:0]   r_pre_cnt;
  logic [PRE_CW-1:0]   w_pre_cnt_next;
  logic [BEAT_CW-1:0]  r_beat_cnt;
  logic [BEAT_CW-1:0]  w_beat_cnt_next;
  logic [PA_K-1:0]     r_hash_out;

  logic w_rnd_ready;
  logic w_key_ready;
  logic w_key_en;
  logic w_hash_valid;
  logic w_busy;
  logic w_done;
  logic w_capture;
  logic w_last_beat;
  logic w_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pre_cnt  <= '0;
      r_beat_cnt <= '0;
      r_hash_out <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pre_cnt  <= w_pre_cnt_next;
      r_beat_cnt <= w_beat_cnt_next;
      // The core still holds the final sums on this edge; it clears them on the same edge.
      if (w_capture) begin
        r_hash_out <= bus.hash_product;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pre_cnt_next  = r_pre_cnt;
    w_beat_cnt_next = r_beat_cnt;
    w_rnd_ready     = 1'b0;
    w_key_ready     = 1'b0;
    w_key_en        = 1'b0;
    w_hash_valid    = 1'b0;
    w_busy          = 1'b0;
    w_done          = 1'b0;
    w_capture       = 1'b0;
    w_last_beat     = (r_beat_cnt == BEAT_CW'(KEY_WORDS - 1));
    // The last beat only consumes a key word: the chain already holds every word it needs.
    w_fire          = bus.key_valid & (w_last_beat | bus.rnd_valid);

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next    = S_PRELOAD;
          w_pre_cnt_next  = '0;
          w_beat_cnt_next = '0;
        end
      end
      S_PRELOAD: begin
        w_busy      = 1'b1;
        w_rnd_ready = 1'b1;
        if (bus.rnd_valid) begin
          w_pre_cnt_next = r_pre_cnt + PRE_CW'(1);
          if (r_pre_cnt == PRE_CW'(PA_S - 1)) begin
            w_state_next = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        // key_en stays high even on stalls; a zero key_bit keeps the core sums unchanged.
        w_busy   = 1'b1;
        w_key_en = 1'b1;
        if (w_fire) begin
          w_key_ready     = 1'b1;
          w_rnd_ready     = ~w_last_beat;
          w_beat_cnt_next = r_beat_cnt + BEAT_CW'(1);
          if (w_last_beat) begin
            w_state_next = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        w_busy       = 1'b1;
        w_capture    = 1'b1;
        w_state_next = S_OUT;
      end
      S_OUT: begin
        w_busy       = 1'b1;
        w_hash_valid = 1'b1;
        if (bus.hash_ready) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (!rst_n) begin
      w_rnd_ready  = 1'b0;
      w_key_ready  = 1'b0;
      w_key_en     = 1'b0;
      w_hash_valid = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_capture    = 1'b0;
    end
  end

  assign bus.rnd_ready  = w_rnd_ready;
  assign bus.key_ready  = w_key_ready;
  assign bus.shift_en   = bus.rnd_valid & w_rnd_ready;
  assign bus.random_bit = w_rnd_ready ? bus.rnd_word : '0;
  assign bus.key_en     = w_key_en;
  assign bus.key_bit    = w_key_ready ? bus.key_word : '0;
  assign bus.hash_out   = rst_n ? r_hash_out : '0;
  assign bus.hash_valid = w_hash_valid;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
endmodule

// File: tb/tb_pa_hash_sequencer.sv
// Directed bench: three sequencers (KEY_WORDS 1, 2, 4) each driving a behavioural Toeplitz core.
// Hash results are checked against hand-derived constants and an independent golden formula.
module tb_pa_hash_sequencer;
  localparam int PA_W = 64;
  localparam int PA_K = 1024;
  localparam int PA_S = 17;
  localparam int NI   = 3;
  localparam int NR   = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NI-1:0]   start_a, rnd_valid_a, key_valid_a, hash_ready_a;
  logic [PA_W-1:0] rnd_word_a [NI];
  logic [PA_W-1:0] key_word_a [NI];
  logic [NI-1:0]   rnd_ready_a, key_ready_a, shift_en_a, key_en_a, hash_valid_a, busy_a, done_a;
  logic [PA_W-1:0] random_bit_a [NI];
  logic [PA_W-1:0] key_bit_a [NI];
  logic [PA_K-1:0] hash_out_a [NI];

  logic [PA_W-1:0] rnd_q [NR];
  logic [PA_W-1:0] key_q [8];

  int n_cmp = 0;
  int n_bad = 0;

  // Run results
  logic [PA_K-1:0] res_hash;
  int res_cycles, res_rnd_hs, res_key_hs, res_done_cnt, res_keyen_gap;
  int res_stall_bad, res_stall_cnt, res_ken_cyc, res_valid_cyc, res_hold_bad;

  function automatic logic [PA_K-1:0] mac_product(input logic [PA_S*PA_W-1:0] w,
                                                  input logic [PA_W-1:0] key);
    logic [PA_K-1:0] p;
    p = '0;
    for (int i = 0; i < PA_K; i++) p[PA_K-1-i] = ^(w[i+1 +: PA_W] & key);
    return p;
  endfunction

  // Chain state at beat j holds the newest word at the bottom: word p = r[PA_S+j-1-p].
  function automatic logic [PA_K-1:0] golden(input int kw);
    logic [PA_S*PA_W-1:0] w;
    logic [PA_K-1:0]      h;
    h = '0;
    for (int j = 0; j < kw; j++) begin
      for (int p = 0; p < PA_S; p++) w[p*PA_W +: PA_W] = rnd_q[PA_S+j-1-p];
      h = h ^ mac_product(w, key_q[j]);
    end
    return h;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int KW = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
      pa_hash_sequencer_if #(.PA_W(PA_W), .PA_K(PA_K)) bus ();
      logic [PA_S*PA_W-1:0] chain;
      logic [PA_K-1:0]      sums;

      assign bus.start        = start_a[gi];
      assign bus.rnd_valid    = rnd_valid_a[gi];
      assign bus.rnd_word     = rnd_word_a[gi];
      assign bus.key_valid    = key_valid_a[gi];
      assign bus.key_word     = key_word_a[gi];
      assign bus.hash_ready   = hash_ready_a[gi];
      assign bus.hash_product = sums;
      assign rnd_ready_a[gi]  = bus.rnd_ready;
      assign key_ready_a[gi]  = bus.key_ready;
      assign shift_en_a[gi]   = bus.shift_en;
      assign key_en_a[gi]     = bus.key_en;
      assign hash_valid_a[gi] = bus.hash_valid;
      assign busy_a[gi]       = bus.busy;
      assign done_a[gi]       = bus.done;
      assign random_bit_a[gi] = bus.random_bit;
      assign key_bit_a[gi]    = bus.key_bit;
      assign hash_out_a[gi]   = bus.hash_out;

      // Behavioural core: sums clear whenever key_en is low; MAC and shift share an edge.
      always_ff @(posedge clk) begin
        if (!rst_n) sums <= '0;
        else if (bus.key_en) sums <= sums ^ mac_product(chain, bus.key_bit);
        else sums <= '0;
        if (bus.shift_en) chain <= {chain[PA_S*PA_W-PA_W-1:0], bus.random_bit};
      end

      pa_hash_sequencer #(.PA_W(PA_W), .PA_K(PA_K), .PA_S(PA_S), .KEY_WORDS(KW)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
      );
    end
  endgenerate

  task automatic fill_rnd_const(input logic [PA_W-1:0] v);
    for (int i = 0; i < NR; i++) rnd_q[i] = v;
  endtask

  task automatic fill_rnd_lfsr(input logic [PA_W-1:0] seed);
    logic [PA_W-1:0] x;
    x = seed;
    for (int i = 0; i < NR; i++) begin
      rnd_q[i] = x;
      x = {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    end
  endtask

  // Drives one block on instance k from rnd_q/key_q. Starts and ends just after a posedge.
  task automatic run_block(input int k, input int kw, input int stall, input int hold,
                           input int rst_beat);
    int ri, ki, kdel, cyc, held;
    bit fin, ken_prev, seen_ken, hv_prev, rst_now;
    logic [PA_K-1:0] hv;
    ri = 0; ki = 0; kdel = stall; cyc = 0; held = 0;
    fin = 0; ken_prev = 0; seen_ken = 0; hv_prev = 0; hv = '0;
    res_hash = '0; res_cycles = -1; res_done_cnt = 0; res_keyen_gap = 0;
    res_stall_bad = 0; res_stall_cnt = 0; res_ken_cyc = 0; res_hold_bad = 0;
    while (!fin && cyc < 400) begin
      rnd_valid_a[k]  = (ri < NR);
      rnd_word_a[k]   = (ri < NR) ? rnd_q[ri] : '0;
      key_valid_a[k]  = (ki < kw) && (kdel == 0);
      key_word_a[k]   = (ki < kw) ? key_q[ki] : '0;
      hash_ready_a[k] = (held >= hold);
      start_a[k]      = (cyc == 0) || (cyc == 5) || hv_prev;
      rst_now         = (rst_beat >= 0) && (ki == rst_beat) && ken_prev;
      if (rst_now) rst_n = 1'b0;
      @(negedge clk);
      if (key_en_a[k]) begin
        seen_ken = 1;
        res_ken_cyc++;
      end
      if (seen_ken && ki < kw && !key_en_a[k] && !rst_now) res_keyen_gap++;
      if (key_en_a[k] && !key_ready_a[k]) begin
        res_stall_cnt++;
        if (shift_en_a[k] || rnd_ready_a[k] || key_bit_a[k] != '0) res_stall_bad++;
      end
      if (rnd_valid_a[k] && rnd_ready_a[k]) ri++;
      if (key_valid_a[k] && key_ready_a[k]) begin
        ki++;
        kdel = stall;
      end else if (key_en_a[k] && kdel > 0) begin
        kdel--;
      end
      if (hash_valid_a[k]) begin
        if (held == 0) hv = hash_out_a[k];
        else if (hash_out_a[k] !== hv) res_hold_bad++;
        held++;
      end
      if (done_a[k]) begin
        res_done_cnt++;
        res_cycles = cyc;
        res_hash   = hash_out_a[k];
        fin        = 1;
      end
      ken_prev = key_en_a[k];
      hv_prev  = hash_valid_a[k];
      @(posedge clk);
      #1;
      if (rst_now) begin
        rst_n = 1'b1;
        fin   = 1;
      end
      cyc++;
    end
    start_a[k] = 1'b0; rnd_valid_a[k] = 1'b0; key_valid_a[k] = 1'b0; hash_ready_a[k] = 1'b0;
    res_rnd_hs = ri; res_key_hs = ki; res_valid_cyc = held;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL block_timeout inst=%0d: no done after %0d cycles, required done", k, cyc);
    end
    $display("block inst=%0d kw=%0d cycles=%0d rnd_hs=%0d key_hs=%0d done=%0d hash_lo=%h",
             k, kw, res_cycles, ri, ki, res_done_cnt, res_hash[63:0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = '0; hash_ready_a = '1; rnd_valid_a = '1; key_valid_a = '1;
    for (int k = 0; k < NI; k++) begin
      rnd_word_a[k] = '1;
      key_word_a[k] = '1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({rnd_ready_a[k], key_ready_a[k], shift_en_a[k], key_en_a[k], hash_valid_a[k],
           busy_a[k], done_a[k], random_bit_a[k], key_bit_a[k], hash_out_a[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs inst=%0d: ctl=%b rbit=%h kbit=%h, required all zero", k,
                 {rnd_ready_a[k], key_ready_a[k], shift_en_a[k], key_en_a[k], hash_valid_a[k],
                  busy_a[k], done_a[k]}, random_bit_a[k], key_bit_a[k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rnd_valid_a = '0; key_valid_a = '0; hash_ready_a = '0;
    @(negedge clk);
    n_cmp++;
    if (busy_a !== 3'b000) begin
      n_bad++;
      $display("FAIL after_reset_busy: got %b, required 000", busy_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_key;
    fill_rnd_const('1);
    key_q[0] = 64'h1;
    run_block(0, 1, 0, 0, -1);
    n_cmp++;
    if (res_hash !== {PA_K{1'b1}}) begin
      n_bad++;
      $display("FAIL t1_hash: got lo=%h, required all ones", res_hash[63:0]);
    end
    n_cmp++;
    if (res_cycles != PA_S + 3) begin
      n_bad++;
      $display("FAIL t1_latency: got %0d, required %0d", res_cycles, PA_S + 3);
    end
    n_cmp++;
    if (res_rnd_hs != 17 || res_key_hs != 1) begin
      n_bad++;
      $display("FAIL t1_handshakes: got rnd=%0d key=%0d, required 17/1", res_rnd_hs, res_key_hs);
    end
    @(negedge clk);
    n_cmp++;
    if (hash_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_post_done: got valid=%b busy=%b, required 0/0", hash_valid_a[0], busy_a[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_keys;
    fill_rnd_const('1);
    key_q[0] = 64'h1;
    key_q[1] = 64'h1;
    run_block(1, 2, 0, 0, -1);
    n_cmp++;
    if (res_hash !== '0) begin
      n_bad++;
      $display("FAIL t2_hash: got lo=%h, required all zeros", res_hash[63:0]);
    end
    n_cmp++;
    if (res_rnd_hs != 18 || res_key_hs != 2) begin
      n_bad++;
      $display("FAIL t2_handshakes: got rnd=%0d key=%0d, required 18/2", res_rnd_hs, res_key_hs);
    end
    n_cmp++;
    if (res_cycles != PA_S + 4) begin
      n_bad++;
      $display("FAIL t2_latency: got %0d, required %0d", res_cycles, PA_S + 4);
    end
  endtask

  task automatic test_key_stalls;
    logic [PA_K-1:0] base, gold;
    fill_rnd_lfsr(64'h1234_5678_9abc_def1);
    key_q[0] = 64'hdead_beef_0123_4567;
    key_q[1] = 64'h8000_0000_0000_0001;
    key_q[2] = 64'h0f0f_3c3c_a5a5_00ff;
    key_q[3] = 64'hffff_0000_ffff_0000;
    gold = golden(4);
    run_block(2, 4, 0, 0, -1);
    base = res_hash;
    n_cmp++;
    if (base !== gold) begin
      n_bad++;
      $display("FAIL t3_nostall_golden: got lo=%h, required lo=%h", base[63:0], gold[63:0]);
    end
    run_block(2, 4, 3, 0, -1);
    n_cmp++;
    if (res_hash !== gold || res_hash !== base) begin
      n_bad++;
      $display("FAIL t3_stall_hash: got lo=%h, required lo=%h", res_hash[63:0], gold[63:0]);
    end
    n_cmp++;
    if (res_keyen_gap != 0 || res_ken_cyc != 16) begin
      n_bad++;
      $display("FAIL t3_key_en: got gaps=%0d high_cycles=%0d, required 0/16", res_keyen_gap, res_ken_cyc);
    end
    n_cmp++;
    if (res_stall_cnt != 12 || res_stall_bad != 0) begin
      n_bad++;
      $display("FAIL t3_stall_strobes: got stalls=%0d bad=%0d, required 12/0", res_stall_cnt, res_stall_bad);
    end
    n_cmp++;
    if (res_rnd_hs != 20 || res_key_hs != 4) begin
      n_bad++;
      $display("FAIL t3_handshakes: got rnd=%0d key=%0d, required 20/4", res_rnd_hs, res_key_hs);
    end
    n_cmp++;
    if (res_cycles != PA_S + 6 + 12) begin
      n_bad++;
      $display("FAIL t3_latency: got %0d, required %0d", res_cycles, PA_S + 18);
    end
  endtask

  task automatic test_hold_ready;
    fill_rnd_const('1);
    key_q[0] = 64'h1;
    run_block(0, 1, 0, 10, -1);
    n_cmp++;
    if (res_hash !== {PA_K{1'b1}}) begin
      n_bad++;
      $display("FAIL t4_hash: got lo=%h, required all ones", res_hash[63:0]);
    end
    n_cmp++;
    if (res_hold_bad != 0 || res_valid_cyc != 11) begin
      n_bad++;
      $display("FAIL t4_hold: got changes=%0d valid_cycles=%0d, required 0/11", res_hold_bad, res_valid_cyc);
    end
    n_cmp++;
    if (res_done_cnt != 1 || res_cycles != PA_S + 13) begin
      n_bad++;
      $display("FAIL t4_done: got pulses=%0d at %0d, required 1 at %0d", res_done_cnt, res_cycles, PA_S + 13);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_a[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_start_ignored: got busy=%b, required 0", busy_a[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_block;
    fill_rnd_lfsr(64'h0bad_cafe_f00d_1234);
    key_q[0] = 64'h5555_aaaa_1234_8765;
    key_q[1] = 64'h0000_ffff_0000_ffff;
    key_q[2] = 64'h1;
    key_q[3] = 64'h2;
    run_block(2, 4, 0, 0, 2);
    rnd_valid_a[2] = 1'b1; key_valid_a[2] = 1'b1;
    rnd_word_a[2]  = '1;   key_word_a[2]  = '1;
    @(negedge clk);
    n_cmp++;
    if ({rnd_ready_a[2], key_ready_a[2], shift_en_a[2], key_en_a[2], hash_valid_a[2],
         busy_a[2], done_a[2], random_bit_a[2], key_bit_a[2], hash_out_a[2]} !== '0) begin
      n_bad++;
      $display("FAIL t5_outputs_after_reset: ctl=%b hash_lo=%h, required all zero",
               {rnd_ready_a[2], key_ready_a[2], shift_en_a[2], key_en_a[2], hash_valid_a[2],
                busy_a[2], done_a[2]}, hash_out_a[2][63:0]);
    end
    n_cmp++;
    if (res_done_cnt != 0 || res_key_hs != 2) begin
      n_bad++;
      $display("FAIL t5_abandoned: got done=%0d key_hs=%0d, required 0/2", res_done_cnt, res_key_hs);
    end
    @(posedge clk); #1;
    rnd_valid_a[2] = 1'b0; key_valid_a[2] = 1'b0;
    fill_rnd_const('1);
    key_q[0] = 64'h1; key_q[1] = '0; key_q[2] = '0; key_q[3] = '0;
    run_block(2, 4, 0, 0, -1);
    n_cmp++;
    if (res_hash !== {PA_K{1'b1}} || res_cycles != PA_S + 6) begin
      n_bad++;
      $display("FAIL t5_rerun: got lo=%h at %0d, required all ones at %0d", res_hash[63:0], res_cycles, PA_S + 6);
    end
  endtask

  task automatic test_back_to_back;
    logic [PA_K-1:0] gold;
    fill_rnd_lfsr(64'h9e37_79b9_7f4a_7c15);
    for (int j = 0; j < 4; j++) key_q[j] = '0;
    gold = golden(4);
    run_block(2, 4, 0, 0, -1);
    n_cmp++;
    if (res_hash !== '0 || res_hash !== gold) begin
      n_bad++;
      $display("FAIL t6_zero_key: got lo=%h, required zero", res_hash[63:0]);
    end
    fill_rnd_lfsr(64'h0123_4567_89ab_cdef);
    key_q[0] = 64'hcafe_babe_dead_beef;
    key_q[1] = 64'h7777_0000_3333_1111;
    key_q[2] = 64'h8000_0000_0000_0000;
    key_q[3] = 64'h0101_0101_0101_0101;
    gold = golden(4);
    run_block(2, 4, 0, 0, -1);
    n_cmp++;
    if (res_hash !== gold) begin
      n_bad++;
      $display("FAIL t6_second_block: got lo=%h, required lo=%h", res_hash[63:0], gold[63:0]);
    end
    n_cmp++;
    if (res_cycles != PA_S + 6 || res_rnd_hs != 20) begin
      n_bad++;
      $display("FAIL t6_second_timing: got cycles=%0d rnd=%0d, required %0d/20", res_cycles, res_rnd_hs, PA_S + 6);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rnd_word_a[k] = '0;
      key_word_a[k] = '0;
    end
    start_a = '0; rnd_valid_a = '0; key_valid_a = '0; hash_ready_a = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_key();
    test_two_keys();
    test_key_stalls();
    test_hold_ready();
    test_reset_mid_block();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
